// File: rtl/bot_trail_pkg.sv
// Shared types and constants for the Rojobot breadcrumb-trail recorder.
package bot_trail_pkg;

  localparam int MAP_BITS  = 7;
  localparam int MAP_CELLS = 16384;

  typedef logic [2*MAP_BITS-1:0] map_addr_t;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RD_NEW,
    ST_WR_NEW,
    ST_RD_OLD,
    ST_WR_OLD
  } trail_state_t;

  function automatic logic in_map(input logic [10:0] row, input logic [10:0] col);
    return (row < 11'd128) && (col < 11'd128);
  endfunction

endpackage

// File: rtl/bot_trail_if.sv
// Location-event, clear and video-query signals between bot/colorizer and bot_trail.
interface bot_trail_if #(
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
);
  logic          upd_sysregs;
  logic [7:0]    LocX;
  logic [7:0]    LocY;
  logic          trail_clr;
  logic [10:0]   vid_row;
  logic [10:0]   vid_col;
  logic          trail_pixel;
  logic [CW-1:0] trail_count;
  logic          busy;

  modport master (
    output upd_sysregs, LocX, LocY, trail_clr, vid_row, vid_col,
    input  trail_pixel, trail_count, busy
  );

  modport slave (
    input  upd_sysregs, LocX, LocY, trail_clr, vid_row, vid_col,
    output trail_pixel, trail_count, busy
  );
endinterface

// File: rtl/bot_trail_ram.sv
// Occupancy-count RAM: port A read/write, port B read-only, both synchronous read-first.
module trail_ram #(
  parameter int AW = 14,
  parameter int DW = 7
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    a_rdata <= mem[a_addr];
  end

  always_ff @(posedge clk) begin
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/bot_trail.sv
// Breadcrumb-trail recorder: location FIFO plus per-cell occupancy counts.
// Optional BOT_TRAIL_DEDUP_EN drops events repeating the last recorded location.
module bot_trail
  import bot_trail_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic        clk,
  input logic        reset,
  bot_trail_if.slave bus
);

  localparam int PW = $clog2(DEPTH);

  trail_state_t  state_q, state_d;
  map_addr_t     clr_addr_q, clr_addr_d;
  map_addr_t     pend_loc_q, pend_loc_d;
  map_addr_t     new_q, new_d;
  map_addr_t     old_q, old_d;
  logic          pend_q, pend_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_range_q, in_range_d;
  logic          clr_take;
  logic          fifo_we;
  logic          dup_hit;
  map_addr_t     fifo_q [DEPTH];

  logic          a_we;
  map_addr_t     a_addr;
  logic [CW-1:0] a_wdata, a_rdata, b_rdata;

  logic          unused_loc_bits;
  assign unused_loc_bits = ^{bus.LocX[7], bus.LocY[7]};

`ifdef BOT_TRAIL_DEDUP_EN
  map_addr_t last_loc_q, last_loc_d;
  logic      last_vld_q, last_vld_d;
  assign dup_hit = last_vld_q && (pend_loc_q == last_loc_q);
`else
  assign dup_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    pend_loc_d = pend_loc_q;
    new_d      = new_q;
    old_d      = old_q;
    pend_d     = pend_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    in_range_d = in_map(bus.vid_row, bus.vid_col);
    clr_take   = 1'b0;
    fifo_we    = 1'b0;
    a_we       = 1'b0;
    a_addr     = new_q;
    a_wdata    = '0;
`ifdef BOT_TRAIL_DEDUP_EN
    last_loc_d = last_loc_q;
    last_vld_d = last_vld_q;
`endif

    case (state_q)
      ST_CLEAR: begin
        a_we       = 1'b1;
        a_addr     = clr_addr_q;
        clr_addr_d = clr_addr_q + 14'd1;
        if (clr_addr_q == map_addr_t'(MAP_CELLS - 1)) begin
          state_d  = ST_IDLE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
`ifdef BOT_TRAIL_DEDUP_EN
          last_vld_d = 1'b0;
`endif
        end
      end
      ST_IDLE: begin
        if (bus.trail_clr) begin
          clr_take   = 1'b1;
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          pend_d     = 1'b0;
        end else if (pend_q) begin
          pend_d = 1'b0;
          if (!dup_hit) begin
            new_d   = pend_loc_q;
            state_d = ST_RD_NEW;
          end
        end
      end
      ST_RD_NEW: state_d = ST_WR_NEW;
      ST_WR_NEW: begin
        a_we     = 1'b1;
        a_wdata  = a_rdata + CW'(1);
        fifo_we  = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
`ifdef BOT_TRAIL_DEDUP_EN
        last_loc_d = new_q;
        last_vld_d = 1'b1;
`endif
        // A full FIFO has rd_ptr == wr_ptr; the async read sees the entry before it is overwritten.
        if (count_q == CW'(DEPTH)) begin
          old_d    = fifo_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + PW'(1);
          state_d  = ST_RD_OLD;
        end else begin
          count_d = count_q + CW'(1);
          state_d = ST_IDLE;
        end
      end
      ST_RD_OLD: begin
        a_addr  = old_q;
        state_d = ST_WR_OLD;
      end
      ST_WR_OLD: begin
        a_we    = 1'b1;
        a_addr  = old_q;
        a_wdata = a_rdata - CW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase

    if (bus.upd_sysregs && (state_q != ST_CLEAR) && !clr_take) begin
      pend_d     = 1'b1;
      pend_loc_d = {bus.LocY[6:0], bus.LocX[6:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      pend_loc_q <= '0;
      new_q      <= '0;
      old_q      <= '0;
      pend_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_range_q <= 1'b0;
`ifdef BOT_TRAIL_DEDUP_EN
      last_loc_q <= '0;
      last_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      pend_loc_q <= pend_loc_d;
      new_q      <= new_d;
      old_q      <= old_d;
      pend_q     <= pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_range_q <= in_range_d;
`ifdef BOT_TRAIL_DEDUP_EN
      last_loc_q <= last_loc_d;
      last_vld_q <= last_vld_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_we) fifo_q[wr_ptr_q] <= new_q;
  end

  trail_ram #(.AW(2*MAP_BITS), .DW(CW)) u_ram (
    .clk     (clk),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_rdata (a_rdata),
    .b_addr  ({bus.vid_row[6:0], bus.vid_col[6:0]}),
    .b_rdata (b_rdata)
  );

  assign bus.trail_pixel = in_range_q && (b_rdata != '0);
  assign bus.trail_count = count_q;
  assign bus.busy        = (state_q == ST_CLEAR);

  // Evictions only ever remove a location that an earlier push incremented.
  assert property (@(posedge clk) disable iff (reset)
                   (state_q == ST_WR_OLD) |-> (a_rdata != '0));

endmodule

// File: tb/tb_bot_trail.sv
// Directed scoreboard bench for bot_trail with DEPTH=4 (honours BOT_TRAIL_DEDUP_EN).
module tb_bot_trail;

  localparam int DEPTH = 4;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  bot_trail_if #(.DEPTH(DEPTH)) bus ();

  bot_trail #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input int kind, input logic [31:0] val, input string tag);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // kind 0: trail_pixel, 1: trail_count, 2: busy
  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: observed 0 entries, expected at least 1");
    end else begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = 32'(bus.trail_pixel);
        1:       obs = 32'(bus.trail_count);
        default: obs = 32'(bus.busy);
      endcase
      compareVal(e.tag, obs, e.val);
    end
  endtask

  task automatic checkNow(input int kind, input logic [31:0] val, input string tag);
    pushExp(kind, val, tag);
    checkOutput();
  endtask

  task automatic applyStimulus(input int x, input int y);
    bus.upd_sysregs = 1'b1;
    bus.LocX        = 8'(x);
    bus.LocY        = 8'(y);
    @(negedge clk);
    bus.upd_sysregs = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic queryCell(input int col, input int row, input bit exp, input string tag);
    bus.vid_col = 11'(col);
    bus.vid_row = 11'(row);
    pushExp(0, 32'(exp), tag);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic waitClearDone(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 20000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    vectors         = 0;
    miscompares     = 0;
    reset           = 1'b1;
    bus.upd_sysregs = 1'b0;
    bus.LocX        = '0;
    bus.LocY        = '0;
    bus.trail_clr   = 1'b0;
    bus.vid_row     = '0;
    bus.vid_col     = '0;

    repeat (3) @(negedge clk);
    checkNow(0, 0, "reset_pixel");
    checkNow(1, 0, "reset_count");
    checkNow(2, 1, "reset_busy");

    reset = 1'b0;
    waitClearDone(n);
    compareVal("clear_cycles", 32'(n), 32'd16384);
    checkNow(1, 0, "count_after_clear");

    for (int i = 0; i < 16384; i++) begin
      queryCell(i % 128, i / 128, 1'b0, "sweep_empty");
    end

    // Latency of the first event: count after cycle 3, pixel for a cycle-4 query
    bus.upd_sysregs = 1'b1;
    bus.LocX        = 8'd1;
    bus.LocY        = 8'd1;
    @(negedge clk);
    bus.upd_sysregs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkNow(1, 0, "count_before_wr_new");
    @(negedge clk);
    checkNow(1, 1, "count_after_wr_new");
    queryCell(1, 1, 1'b1, "first_cell_latency");
    repeat (3) @(negedge clk);

    applyStimulus(2, 1);
    applyStimulus(3, 1);
    applyStimulus(4, 1);
    checkNow(1, 4, "count_full");
    for (int x = 1; x <= 4; x++) queryCell(x, 1, 1'b1, "filled_cell");
    queryCell(5, 1, 1'b0, "unvisited_cell");
    queryCell(1, 129, 1'b0, "row_out_of_range");
    queryCell(129, 1, 1'b0, "col_out_of_range");
    queryCell(1, 200, 1'b0, "row_200");

    applyStimulus(5, 1);
    checkNow(1, 4, "count_held_at_depth");
    queryCell(1, 1, 1'b0, "evicted_cell");
    queryCell(5, 1, 1'b1, "newest_cell");
    queryCell(2, 1, 1'b1, "surviving_cell");

    applyStimulus(7, 7);
    applyStimulus(8, 8);
    applyStimulus(7, 7);
    applyStimulus(9, 9);
    applyStimulus(10, 10);
    checkNow(1, 4, "count_after_revisit");
    queryCell(7, 7, 1'b1, "revisit_survives_eviction");
    queryCell(10, 10, 1'b1, "cell_10_10");
    queryCell(5, 1, 1'b0, "cell_5_1_evicted");
    applyStimulus(11, 11);
    queryCell(8, 8, 1'b0, "cell_8_8_evicted");
    queryCell(7, 7, 1'b1, "revisit_still_live");
    applyStimulus(12, 12);
    queryCell(7, 7, 1'b0, "revisit_fully_evicted");

    // Clear request collides with an event and an out-of-range query
    bus.trail_clr   = 1'b1;
    bus.upd_sysregs = 1'b1;
    bus.LocX        = 8'd20;
    bus.LocY        = 8'd20;
    bus.vid_row     = 11'd200;
    bus.vid_col     = 11'd5;
    pushExp(0, 0, "clr_query_row_200");
    @(negedge clk);
    bus.trail_clr   = 1'b0;
    bus.upd_sysregs = 1'b0;
    checkOutput();
    checkNow(2, 1, "busy_on_clear");
    repeat (100) @(negedge clk);
    applyStimulus(30, 30);
    checkNow(2, 1, "busy_mid_sweep");
    waitClearDone(n);
    checkNow(2, 0, "busy_after_clear");
    checkNow(1, 0, "count_after_trail_clr");
    queryCell(20, 20, 1'b0, "dropped_clr_event");
    queryCell(30, 30, 1'b0, "dropped_busy_event");
    queryCell(10, 10, 1'b0, "cleared_cell");

    applyStimulus(3, 3);
    applyStimulus(3, 3);
    applyStimulus(3, 3);
`ifdef BOT_TRAIL_DEDUP_EN
    checkNow(1, 1, "stationary_count");
`else
    checkNow(1, 3, "stationary_count");
`endif
    queryCell(3, 3, 1'b1, "stationary_cell");

    // Pending register: B arrives during RD_NEW of A, C overwrites it during WR_NEW
    bus.upd_sysregs = 1'b1;
    bus.LocX        = 8'd40;
    bus.LocY        = 8'd40;
    @(negedge clk);
    bus.upd_sysregs = 1'b0;
    @(negedge clk);
    bus.upd_sysregs = 1'b1;
    bus.LocX        = 8'd41;
    bus.LocY        = 8'd41;
    @(negedge clk);
    bus.LocX        = 8'd42;
    bus.LocY        = 8'd42;
    @(negedge clk);
    bus.upd_sysregs = 1'b0;
    repeat (10) @(negedge clk);
    queryCell(40, 40, 1'b1, "pend_first");
    queryCell(41, 41, 1'b0, "pend_overwritten");
    queryCell(42, 42, 1'b1, "pend_latest");
    queryCell(3, 3, 1'b1, "stationary_after_evict");
`ifdef BOT_TRAIL_DEDUP_EN
    checkNow(1, 3, "count_after_pend");
`else
    checkNow(1, 4, "count_after_pend");
`endif

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: observed %0d entries, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bot_trail.md
# bot_trail

Breadcrumb-trail recorder for the Rojobot display path. Samples the bot's map location on every `upd_sysregs` pulse and keeps the last `DEPTH` recorded positions in a circular location FIFO. Maintains a per-cell occupancy map of the 128x128 world and answers the video pipeline's per-pixel "was the bot here" query. Sits beside `bot`, with the same location inputs and the same scaled `vid_row`/`vid_col` addressing, and feeds a trail overlay bit to `colorizer`.

## Interface
- `DEPTH`, 64: trail length in recorded positions; power of two, 2..256.
- `CW`, `$clog2(DEPTH)+1`: occupancy-count width (derived; do not override).
- `clk`  in  1  system clock (66 MHz sysclk domain).
- `reset`  in  1  asynchronous, active-high reset.
- `upd_sysregs`  in  1  one-cycle pulse from `bot`: `LocX`/`LocY` updated.
- `LocX`  in  8  bot X map coordinate; bits [6:0] used.
- `LocY`  in  8  bot Y map coordinate; bits [6:0] used.
- `trail_clr`  in  1  synchronous clear request, level-sampled, one-cycle pulse.
- `vid_row`  in  11  map-scaled video row (row/6).
- `vid_col`  in  11  map-scaled video column (col/8).
- `trail_pixel`  out  1  registered: 1 when the queried cell holds at least one live trail entry.
- `trail_count`  out  `CW`  number of live entries in the FIFO, 0..DEPTH.
- `busy`  out  1  high while a clear sweep is in progress.

## Operation
- Occupancy RAM: 16384 x `CW`, address `{y[6:0], x[6:0]}`.
  - Port A: read-modify-write by the FSM.
  - Port B: read-only video port.
- Location FIFO: `DEPTH` x 14 bits, with `wr_ptr`, `rd_ptr` and `trail_count`. Pointers wrap modulo `DEPTH`.
- Event capture:
  - An `upd_sysregs` pulse latches `{LocY[6:0], LocX[6:0]}` into a one-deep pending register and sets `pend`.
  - A new pulse while `pend` is set overwrites the pending location (latest wins).
  - Pulses arriving while `busy` is high are dropped.
- FSM states: CLEAR, IDLE, RD_NEW, WR_NEW, RD_OLD, WR_OLD.
  - CLEAR: sweeps addresses 0..16383, one write of 0 per cycle. At the last address it zeroes the pointers and count and goes to IDLE.
  - IDLE: if `trail_clr` is high, go to CLEAR. This has priority over `pend`, and it discards `pend`. Otherwise, if `pend` is set, take the pending location as `new`, clear `pend`, and go to RD_NEW.
  - RD_NEW: read port A at `new`.
  - WR_NEW: write the read value + 1 at `new`, and push `new` into the FIFO. If `trail_count` was DEPTH, latch FIFO[`rd_ptr`] as `old`, advance `rd_ptr` and go to RD_OLD. Otherwise increment `trail_count` and go to IDLE.
  - RD_OLD: read port A at `old`.
  - WR_OLD: write the read value - 1 at `old`, then go to IDLE. `trail_count` stays at DEPTH.
- An evicted cell equal to `new` is handled correctly because the operations are sequential: +1 then -1.
- The count never exceeds DEPTH, so there is no overflow or underflow. The decrement is never applied to a zero cell; an assertion checks this.
- Video query: if `vid_row`>127 or `vid_col`>127, `trail_pixel` is 0. Otherwise it is (port B data != 0).
- Reset:
  - The FSM enters CLEAR with all pointers, counters, `pend` and `trail_pixel` at 0 and `busy` at 1.
  - The RAM is not reset; the sweep clears it.
  - A reset mid-sweep or mid-RMW restarts the sweep from address 0.

## Timing
- Reset values: `trail_pixel`=0, `trail_count`=0, `busy`=1.
- Clear duration: the first CLEAR cycle follows reset release. `busy` falls in the cycle after address 16383 is written, which is 16384 cycles after entry.
- Event latency (pulse in cycle 0, FSM idle):
  - `pend` is set in cycle 1.
  - RD_NEW occurs in cycle 2 and WR_NEW in cycle 3.
  - `trail_count` updates at the end of cycle 3.
  - The cell is visible on `trail_pixel` for a query presented in cycle 4, output in cycle 5.
- Eviction adds 2 cycles. The worst case is 5 cycles from IDLE back to IDLE, far below the `upd_sysregs` spacing.
- Video port: 1-cycle latency from `vid_row`/`vid_col` to `trail_pixel`, including the out-of-range case.
- Simultaneous port A write and port B read of the same address return the old data (read-first).

## Configuration
- `BOT_TRAIL_DEDUP_EN` defined: an event whose location equals the last recorded (pushed) location is discarded in IDLE, with no RMW and no push. The last-location register is invalidated by reset and by clear.
- `BOT_TRAIL_DEDUP_EN` undefined: every accepted event is recorded, and a stationary bot fills the FIFO with one cell.

## Structure
- Shared package `bot_trail_pkg`:
  - `MAP_BITS`=7.
  - `MAP_CELLS`=16384.
  - The `map_addr_t` (14-bit) typedef.
  - The FSM state enum `trail_state_t`.
- Sub-module `trail_ram`: a simple dual-port RAM with port A read/write and port B read-only. Both ports are synchronous and read-first, and it must infer block RAM.
- The FIFO is distributed RAM with an asynchronous read, inside `bot_trail`.

## Test plan
- Reset, then hold 16384 cycles -> `busy` stays 1 for exactly 16384 cycles after reset release, and `trail_pixel`=0 when querying all cells.
- DEPTH=4: pulses at (1,1),(2,1),(3,1),(4,1) -> `trail_count`=4, and queries at those four cells give `trail_pixel`=1 exactly 1 cycle later.
- DEPTH=4: continue with (5,1) -> `trail_count` stays 4, (1,1) reads 0 and (5,1) reads 1.
- DEPTH=4: sequence (7,7),(8,8),(7,7),(9,9),(10,10) -> (7,7) still reads 1 after the first eviction (count 2 then 1).
- With `BOT_TRAIL_DEDUP_EN`: three pulses at (3,3) -> `trail_count`=1. Without the macro -> `trail_count`=3.
- `trail_clr` raised in the same cycle as `upd_sysregs`, and `vid_row`=200 queried -> the event is dropped, `busy` goes to 1, `trail_count` goes to 0, and `trail_pixel`=0.
